// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/synchroniser input stage.
// Imported by the top level and reusable by other input-conditioning blocks.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } dbnc_state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Bits needed to hold values 0..n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Plain async-reset flop chain that brings a single asynchronous bit into the clk domain.
// Nothing may sit between stages, so the chain is a pure shift register.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces a raw level, producing a clean registered level,
// one-cycle edge pulses, a qualification-busy flag and a saturating glitch count.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_in,
  output logic                a_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_badSync
    $fatal(1, "debounce_sync: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_badDebounce
    $fatal(1, "debounce_sync: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (GLITCH_W < 1) begin : g_badGlitch
    $fatal(1, "debounce_sync: GLITCH_W must be at least 1");
  end

  logic                w_sync;
  dbnc_state_t         r_state, w_stateNext;
  logic [CNT_W-1:0]    r_cnt, w_cntNext;
  logic                r_aOut, w_aOutNext;
  logic                r_rise, r_fall;
  logic                r_busy, w_busyNext;
  logic [GLITCH_W-1:0] r_glitch, w_glitchNext;
  logic                w_glitchInc;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_syncChain (
    .clk    (clk),
    .rst    (rst),
    .i_async(a_in),
    .o_sync (w_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= STABLE_LO;
      r_cnt    <= '0;
      r_aOut   <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
      r_glitch <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_aOut   <= w_aOutNext;
      r_rise   <= w_aOutNext & ~r_aOut;
      r_fall   <= ~w_aOutNext & r_aOut;
      r_busy   <= w_busyNext;
      r_glitch <= w_glitchNext;
    end
  end

  // The count records how many consecutive synced cycles of the candidate level
  // have been seen; a wrong-level cycle aborts back to the stable state.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_glitchInc = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (w_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_stateNext = STABLE_HI;
          end else begin
            w_stateNext = WAIT_HI;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!w_sync) begin
          w_stateNext = STABLE_LO;
          w_cntNext   = '0;
          w_glitchInc = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = STABLE_HI;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!w_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_stateNext = STABLE_LO;
          end else begin
            w_stateNext = WAIT_LO;
            w_cntNext   = CNT_ONE;
          end
        end
      end
      WAIT_LO: begin
        if (w_sync) begin
          w_stateNext = STABLE_HI;
          w_cntNext   = '0;
          w_glitchInc = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_stateNext = STABLE_LO;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNext = STABLE_LO;
        w_cntNext   = '0;
      end
    endcase

    // While qualifying a fall the output is still high, so WAIT_LO counts as high
    w_aOutNext   = (w_stateNext == STABLE_HI) || (w_stateNext == WAIT_LO);
    w_busyNext   = (w_stateNext == WAIT_HI) || (w_stateNext == WAIT_LO);
    w_glitchNext = r_glitch;
    if (w_glitchInc && (r_glitch != {GLITCH_W{1'b1}})) begin
      w_glitchNext = r_glitch + 1'b1;
    end
  end

  assign a_out      = r_aOut;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;
  assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync: default, narrow-glitch-counter
// and single-cycle-debounce instances share clock, reset and input.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rst;
  logic a_in;

  logic       aOut0, rise0, fall0, busy0;
  logic [7:0] glitch0;
  logic       aOut1, rise1, fall1, busy1;
  logic [1:0] glitch1;
  logic       aOut2, rise2, fall2, busy2;
  logic [7:0] glitch2;

  int nVec  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  debounce_sync u_dutDefault (
    .clk(clk), .rst(rst), .a_in(a_in),
    .a_out(aOut0), .rise_pulse(rise0), .fall_pulse(fall0),
    .busy(busy0), .glitch_cnt(glitch0)
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) u_dutNarrow (
    .clk(clk), .rst(rst), .a_in(a_in),
    .a_out(aOut1), .rise_pulse(rise1), .fall_pulse(fall1),
    .busy(busy1), .glitch_cnt(glitch1)
  );

  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .GLITCH_W(8)) u_dutFast (
    .clk(clk), .rst(rst), .a_in(a_in),
    .a_out(aOut2), .rise_pulse(rise2), .fall_pulse(fall2),
    .busy(busy2), .glitch_cnt(glitch2)
  );

  // Advance to just after the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    a_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nVec++; if (aOut0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset a_out: got %b want 0", aOut0); end
    nVec++; if (rise0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset rise_pulse: got %b want 0", rise0); end
    nVec++; if (fall0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset fall_pulse: got %b want 0", fall0); end
    nVec++; if (busy0 !== 1'b0) begin nFail++; $display("[TB] FAIL reset busy: got %b want 0", busy0); end
    nVec++; if (glitch0 !== 8'd0) begin nFail++; $display("[TB] FAIL reset glitch_cnt: got %0d want 0", glitch0); end
  endtask

  // a_in goes high right at reset release; output must follow at edge 6
  task automatic test_rise_latency();
    apply_reset();
    a_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      nVec++; if (aOut0 !== (e >= 6)) begin nFail++; $display("[TB] FAIL rise_lat a_out edge %0d: got %b want %b", e, aOut0, (e >= 6)); end
      nVec++; if (rise0 !== (e == 6)) begin nFail++; $display("[TB] FAIL rise_lat rise_pulse edge %0d: got %b want %b", e, rise0, (e == 6)); end
      nVec++; if (fall0 !== 1'b0) begin nFail++; $display("[TB] FAIL rise_lat fall_pulse edge %0d: got %b want 0", e, fall0); end
      nVec++; if (busy0 !== (e >= 3 && e <= 5)) begin nFail++; $display("[TB] FAIL rise_lat busy edge %0d: got %b want %b", e, busy0, (e >= 3 && e <= 5)); end
    end
  endtask

  // Continues from a_out=1: a two-cycle low dip must be rejected
  task automatic test_glitch_hi();
    a_in = 1'b0;
    tick();
    tick();
    a_in = 1'b1;
    for (int e = 3; e <= 10; e++) begin
      tick();
      nVec++; if (aOut0 !== 1'b1) begin nFail++; $display("[TB] FAIL glitch_hi a_out edge %0d: got %b want 1", e, aOut0); end
      nVec++; if (fall0 !== 1'b0) begin nFail++; $display("[TB] FAIL glitch_hi fall_pulse edge %0d: got %b want 0", e, fall0); end
    end
    nVec++; if (glitch0 !== 8'd1) begin nFail++; $display("[TB] FAIL glitch_hi glitch_cnt: got %0d want 1", glitch0); end
  endtask

  task automatic test_bounce();
    logic [4:0] pattern;
    int nRise;
    pattern = 5'b10101;
    nRise   = 0;
    apply_reset();
    for (int e = 1; e <= 16; e++) begin
      if (e <= 5) a_in = pattern[5-e];
      tick();
      if (rise0 === 1'b1) nRise++;
      nVec++; if (aOut0 !== (e >= 10)) begin nFail++; $display("[TB] FAIL bounce a_out edge %0d: got %b want %b", e, aOut0, (e >= 10)); end
      nVec++; if (rise0 !== (e == 10)) begin nFail++; $display("[TB] FAIL bounce rise_pulse edge %0d: got %b want %b", e, rise0, (e == 10)); end
    end
    nVec++; if (nRise != 1) begin nFail++; $display("[TB] FAIL bounce rise_count: got %0d want 1", nRise); end
    nVec++; if (glitch0 !== 8'd2) begin nFail++; $display("[TB] FAIL bounce glitch_cnt: got %0d want 2", glitch0); end
  endtask

  task automatic test_reset_midqual();
    apply_reset();
    a_in = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    nVec++; if (busy0 !== 1'b1) begin nFail++; $display("[TB] FAIL midqual busy_before: got %b want 1", busy0); end
    #3;
    rst = 1'b1;
    #1;
    nVec++; if (busy0 !== 1'b0) begin nFail++; $display("[TB] FAIL midqual async busy: got %b want 0", busy0); end
    nVec++; if (aOut0 !== 1'b0) begin nFail++; $display("[TB] FAIL midqual async a_out: got %b want 0", aOut0); end
    nVec++; if (glitch0 !== 8'd0) begin nFail++; $display("[TB] FAIL midqual async glitch_cnt: got %0d want 0", glitch0); end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      nVec++; if (aOut0 !== (e >= 6)) begin nFail++; $display("[TB] FAIL midqual a_out edge %0d: got %b want %b", e, aOut0, (e >= 6)); end
    end
    nVec++; if (glitch0 !== 8'd0) begin nFail++; $display("[TB] FAIL midqual glitch_cnt: got %0d want 0", glitch0); end
  endtask

  task automatic test_glitch_saturate();
    logic [1:0] expCnt [5];
    expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int g = 0; g < 5; g++) begin
      a_in = 1'b1;
      tick();
      a_in = 1'b0;
      for (int e = 0; e < 6; e++) tick();
      nVec++; if (glitch1 !== expCnt[g]) begin nFail++; $display("[TB] FAIL saturate glitch_cnt #%0d: got %0d want %0d", g + 1, glitch1, expCnt[g]); end
      nVec++; if (aOut1 !== 1'b0) begin nFail++; $display("[TB] FAIL saturate a_out #%0d: got %b want 0", g + 1, aOut1); end
    end
  endtask

  // Single-cycle debounce with three sync stages: output follows at edge 4
  task automatic test_fast_follow();
    logic prevLvl, newLvl;
    apply_reset();
    prevLvl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      newLvl = ~prevLvl;
      a_in   = newLvl;
      for (int e = 1; e <= 8; e++) begin
        tick();
        nVec++; if (aOut2 !== ((e >= 4) ? newLvl : prevLvl)) begin nFail++; $display("[TB] FAIL fast a_out toggle %0d edge %0d: got %b want %b", k, e, aOut2, ((e >= 4) ? newLvl : prevLvl)); end
        nVec++; if (rise2 !== (e == 4 && newLvl)) begin nFail++; $display("[TB] FAIL fast rise_pulse toggle %0d edge %0d: got %b want %b", k, e, rise2, (e == 4 && newLvl)); end
        nVec++; if (fall2 !== (e == 4 && !newLvl)) begin nFail++; $display("[TB] FAIL fast fall_pulse toggle %0d edge %0d: got %b want %b", k, e, fall2, (e == 4 && !newLvl)); end
        nVec++; if (busy2 !== 1'b0) begin nFail++; $display("[TB] FAIL fast busy toggle %0d edge %0d: got %b want 0", k, e, busy2); end
      end
      prevLvl = newLvl;
    end
  endtask

  initial begin
    rst  = 1'b1;
    a_in = 1'b0;
    $display("[TB] starting debounce_sync directed tests");
    test_reset();
    test_rise_latency();
    test_glitch_hi();
    test_bounce();
    test_reset_midqual();
    test_glitch_saturate();
    test_fast_follow();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input conditioning stage that sits directly upstream of the single-bit logic gates in the simple combinational suite.
- Takes a raw, asynchronous, possibly bouncing level `a_in`.
- Synchronises it into the `clk` domain and debounces it; the result `a_out` is a clean, registered level that drives a downstream gate input (e.g. the inverter).
- Also produces one-cycle edge pulses and a saturating glitch counter for test visibility.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive synced cycles of a new level required before `a_out` follows; legal range 1..255.
- GLITCH_W, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_in  input  1  raw asynchronous level.
- a_out  output  1  debounced, synchronised level; feeds the downstream gate.
- rise_pulse  output  1  high for exactly one cycle, on the first cycle `a_out` is 1.
- fall_pulse  output  1  high for exactly one cycle, on the first cycle `a_out` is 0.
- busy  output  1  high while a candidate level change is being qualified.
- glitch_cnt  output  GLITCH_W  count of aborted candidate changes; saturates at all-ones.

Behaviour:
- Clock and reset: one clock domain, `clk`. Reset is asynchronous and active-high (`rst`). All state and outputs clear immediately on `rst` assertion and are released on the first `clk` edge after deassertion.
- Reset values: sync chain = 0, state = STABLE_LO, cnt = 0, `a_out` = 0, `rise_pulse` = 0, `fall_pulse` = 0, `busy` = 0, `glitch_cnt` = 0.
- Synchroniser:
  - `a_in` passes through SYNC_STAGES flops; `s` denotes the last stage.
  - No logic is permitted between synchroniser stages.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
- STABLE_LO:
  - If s=1 and DEBOUNCE_CYCLES=1: go to STABLE_HI and set `a_out`=1.
  - If s=1 and DEBOUNCE_CYCLES>1: go to WAIT_HI with cnt=1.
  - Otherwise hold.
- WAIT_HI:
  - If s=0: go to STABLE_LO, cnt=0, `glitch_cnt`+1 (saturating).
  - Else if cnt+1 = DEBOUNCE_CYCLES: go to STABLE_HI, `a_out`=1, cnt=0.
  - Else cnt+1.
- STABLE_HI / WAIT_LO: mirror images of the above, with `a_out` going to 0.
- Latency:
  - A clean `a_in` transition held steadily appears on `a_out` at the (SYNC_STAGES + DEBOUNCE_CYCLES)th rising edge after the change.
  - With defaults this is edge 6.
- Pulses:
  - `rise_pulse` and `fall_pulse` are registered.
  - Each is asserted in the same cycle `a_out` changes and for that cycle only.
  - They are never high simultaneously.
  - A new transition cannot complete sooner than DEBOUNCE_CYCLES cycles later, so pulses never merge.
- busy: high exactly when the state is WAIT_HI or WAIT_LO; registered with the state.
- Width rules:
  - cnt is clog2(DEBOUNCE_CYCLES+1) bits and never exceeds DEBOUNCE_CYCLES-1.
  - `glitch_cnt` holds at 2^GLITCH_W-1 once reached.
- Boundary conditions:
  - Glitch shorter than DEBOUNCE_CYCLES synced cycles: `a_out` unchanged, no pulse, `glitch_cnt`+1.
  - Bounce returning to the candidate level: restarts qualification from cnt=1 and counts one glitch per abort.
  - `a_in`=1 at reset release: normal qualification; `a_out` rises after the full latency with a `rise_pulse`. There is no special-case preload.
  - Reset mid-qualification: the count is aborted, outputs return to reset values, and `glitch_cnt` is not incremented.
  - DEBOUNCE_CYCLES=1: the WAIT states are unreachable and `busy` stays 0.
- All outputs are driven directly from flops; no combinational path runs from `a_in` to any output.

Decomposition:
- Package `debounce_pkg`:
  - state enum `dbnc_state_t` (STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO);
  - constants `SYNC_STAGES_MIN`=2 and `SYNC_STAGES_MAX`=4;
  - function `cnt_width(n)` returning clog2(n+1).
- Sub-module `sync_chain`, parameterised by SYNC_STAGES: an async-reset flop chain with a single-bit in/out, reusable by other input stages.
- Top level: the FSM, counter, pulse registers and glitch counter.
- Parameter legality is checked at elaboration and is a fatal error if out of range.

Test Plan:
- Reset then steady `a_in`=1 from edge 0 -> `a_out` 0 through edge 5, 1 from edge 6; `rise_pulse` high only in the cycle after edge 6; `busy` high from edge 3 through edge 5.
- `a_out`=1 stable, `a_in` low for 2 cycles then high -> `a_out` stays 1; no `fall_pulse`; `glitch_cnt` 0->1.
- Bounce pattern 1,0,1,0,1 (one cycle each) then held at 1 from STABLE_LO -> `glitch_cnt`=2; `a_out` rises 6 edges after the final 0->1; exactly one `rise_pulse`.
- Assert `rst` asynchronously between edges while in WAIT_HI with cnt=2 -> all outputs 0 immediately, without waiting for a clock; `glitch_cnt` 0; after release with `a_in`=1, `a_out` rises at edge 6.
- GLITCH_W=2, apply 5 aborted glitches -> `glitch_cnt` reads 1,2,3,3,3.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3, toggle `a_in` every 8 cycles -> `a_out` follows at edge 4 after each change; `busy` never asserts; pulses alternate rise/fall.
